// File: rtl/kettle_pkg.sv
// Shared definitions for the kettle heater controller.
//  - FSM state encodings (IDLE, HEAT, WARM_OFF, WARM_ON, FAULT)
//  - fault_code encodings shown on the UI
//  - default thermal and timing limits
package kettle_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_HEAT     = 3'd1;
  localparam logic [2:0] S_WARM_OFF = 3'd2;
  localparam logic [2:0] S_WARM_ON  = 3'd3;
  localparam logic [2:0] S_FAULT    = 3'd4;

  localparam logic [1:0] FC_NONE      = 2'b00;
  localparam logic [1:0] FC_OVERTEMP  = 2'b01;
  localparam logic [1:0] FC_LOW_WATER = 2'b10;
  localparam logic [1:0] FC_TIMEOUT   = 2'b11;

  localparam int DEF_MAX_TEMP      = 110;
  localparam int DEF_HYST          = 5;
  localparam int DEF_PWM_PERIOD    = 16;
  localparam int DEF_RAMP_STEP_CYC = 64;
  localparam int DEF_TIMEOUT_CYC   = 4096;

endpackage

// File: rtl/kettle_heat_controller_pwm.sv
// Heater PWM generator.
//  clk, rst : clock and synchronous active-high reset
//  en_i     : heater allowed in the current state
//  duty_i   : on-cycles per period, 0..PWM_PERIOD (PWM_PERIOD = always on)
//  gate_o   : registered heater gate, one cycle behind en_i/duty_i
module kettle_pwm #(
  parameter int PWM_PERIOD = 16,
  parameter int DUTY_W     = $clog2(PWM_PERIOD + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              gate_o
);

  localparam logic [DUTY_W-1:0] CNT_LAST = DUTY_W'(PWM_PERIOD - 1);

  logic [DUTY_W-1:0] pwm_cnt_q;
  logic              gate_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      gate_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= (pwm_cnt_q == CNT_LAST) ? '0 : pwm_cnt_q + DUTY_W'(1);
      gate_q    <= en_i & (pwm_cnt_q < duty_i);
    end
  end

  assign gate_o = gate_q;

endmodule

// File: rtl/kettle_heat_controller.sv
// Kettle heater sequencer: soft-start PWM ramp, boil to a latched target,
// optional keep-warm with hysteresis, and safety supervision
// (overtemp, dry boil, heat timeout).
//  clk, rst             : clock, synchronous active-high reset
//  start_button         : start request, rising edge is the event
//  cancel               : abort heat/warm, clear a recoverable fault
//  keep_warm_en         : WARM_OFF vs IDLE on boil completion
//  target_temp          : boil target, latched on start (clamped below MAX_TEMP)
//  temperature_sensor   : water temperature, unsigned
//  water_level_sensor   : 1 = enough water
//  heater               : PWM-gated heater switch
//  heating / keep_warm / fault : state indicators
//  done_pulse           : one cycle after boil completion
//  fault_code           : 00 none, 01 overtemp, 10 low water, 11 timeout
module kettle_heat_controller
  import kettle_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int MAX_TEMP      = DEF_MAX_TEMP,
  parameter int HYST          = DEF_HYST,
  parameter int PWM_PERIOD    = DEF_PWM_PERIOD,
  parameter int RAMP_STEP_CYC = DEF_RAMP_STEP_CYC,
  parameter int TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_button,
  input  logic              cancel,
  input  logic              keep_warm_en,
  input  logic [DATA_W-1:0] target_temp,
  input  logic [DATA_W-1:0] temperature_sensor,
  input  logic              water_level_sensor,
  output logic              heater,
  output logic              heating,
  output logic              keep_warm,
  output logic              done_pulse,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam int DUTY_W = $clog2(PWM_PERIOD + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int RAMP_W = $clog2(RAMP_STEP_CYC + 1);

  localparam logic [DATA_W-1:0] MAX_T     = DATA_W'(MAX_TEMP);
  localparam logic [DATA_W-1:0] MAX_LIM   = DATA_W'(MAX_TEMP - 1);
  localparam logic [DATA_W-1:0] RECOVER_T = DATA_W'(MAX_TEMP - HYST);
  localparam logic [DATA_W-1:0] HYST_T    = DATA_W'(HYST);
  localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_PERIOD);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(TIMEOUT_CYC);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_STEP_CYC - 1);

  function automatic logic [DATA_W-1:0] clamp_tgt(input logic [DATA_W-1:0] t);
    return (t >= MAX_T) ? MAX_LIM : t;
  endfunction

  // Keep-warm low threshold must not wrap when the target is below HYST.
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a >= b) ? a - b : '0;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [RAMP_W-1:0] ramp_q, ramp_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic [1:0]        fcode_q, fcode_d;
  logic              done_q, done_d;
  logic              start_q;

  logic start_edge, over_temp, dry, pwm_en;

  assign start_edge = start_button & ~start_q;
  assign over_temp  = temperature_sensor >= MAX_T;
  assign dry        = ~water_level_sensor;

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    ramp_d  = ramp_q;
    tmo_d   = tmo_q;
    tgt_d   = tgt_q;
    fcode_d = fcode_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          if (dry) begin
            state_d = S_FAULT;
            fcode_d = FC_LOW_WATER;
          end else if (temperature_sensor < clamp_tgt(target_temp)) begin
            state_d = S_HEAT;
            duty_d  = DUTY_W'(1);
            ramp_d  = '0;
            tmo_d   = '0;
            tgt_d   = clamp_tgt(target_temp);
          end
        end
      end
      S_HEAT: begin
        tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
        if (ramp_q == RAMP_LAST) begin
          ramp_d = '0;
          if (duty_q < DUTY_FULL) duty_d = duty_q + DUTY_W'(1);
        end else begin
          ramp_d = ramp_q + RAMP_W'(1);
        end
        if (over_temp) begin
          state_d = S_FAULT;
          fcode_d = FC_OVERTEMP;
        end else if (dry) begin
          state_d = S_FAULT;
          fcode_d = FC_LOW_WATER;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_FAULT;
          fcode_d = FC_TIMEOUT;
        end else if (cancel) begin
          state_d = S_IDLE;
        end else if (temperature_sensor >= tgt_q) begin
          done_d  = 1'b1;
          state_d = keep_warm_en ? S_WARM_OFF : S_IDLE;
        end
      end
      S_WARM_OFF, S_WARM_ON: begin
        if (over_temp) begin
          state_d = S_FAULT;
          fcode_d = FC_OVERTEMP;
        end else if (dry) begin
          state_d = S_FAULT;
          fcode_d = FC_LOW_WATER;
        end else if (cancel) begin
          state_d = S_IDLE;
        end else if (state_q == S_WARM_OFF) begin
          if (temperature_sensor <= sat_sub(tgt_q, HYST_T)) begin
            state_d = S_WARM_ON;
            duty_d  = DUTY_FULL;
          end
        end else if (temperature_sensor >= tgt_q) begin
          state_d = S_WARM_OFF;
        end
      end
      S_FAULT: begin
        // Overtemp keeps overriding the displayed cause while it persists.
        if (over_temp) begin
          fcode_d = FC_OVERTEMP;
        end else if (cancel && temperature_sensor < RECOVER_T && !dry) begin
          state_d = S_IDLE;
          fcode_d = FC_NONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      duty_q  <= '0;
      ramp_q  <= '0;
      tmo_q   <= '0;
      tgt_q   <= '0;
      fcode_q <= FC_NONE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      ramp_q  <= ramp_d;
      tmo_q   <= tmo_d;
      tgt_q   <= tgt_d;
      fcode_q <= fcode_d;
      done_q  <= done_d;
    end
  end

  // Tracked through reset as well, so a button held across reset release
  // is not mistaken for a fresh press.
  always_ff @(posedge clk) begin
    start_q <= start_button;
  end

  assign pwm_en = (state_q == S_HEAT) || (state_q == S_WARM_ON);

  kettle_pwm #(
    .PWM_PERIOD(PWM_PERIOD),
    .DUTY_W    (DUTY_W)
  ) u_pwm (
    .clk   (clk),
    .rst   (rst),
    .en_i  (pwm_en),
    .duty_i(duty_q),
    .gate_o(heater)
  );

  assign heating    = state_q == S_HEAT;
  assign keep_warm  = (state_q == S_WARM_OFF) || (state_q == S_WARM_ON);
  assign fault      = state_q == S_FAULT;
  assign fault_code = fcode_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_kettle_heat_controller.sv
module tb_kettle_heat_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_button, cancel, keep_warm_en, water_level_sensor;
  logic [7:0] target_temp, temperature_sensor;
  logic       heater, heating, keep_warm, done_pulse, fault;
  logic [1:0] fault_code;

  always #5 clk = ~clk;

  kettle_heat_controller dut (
    .clk               (clk),
    .rst               (rst),
    .start_button      (start_button),
    .cancel            (cancel),
    .keep_warm_en      (keep_warm_en),
    .target_temp       (target_temp),
    .temperature_sensor(temperature_sensor),
    .water_level_sensor(water_level_sensor),
    .heater            (heater),
    .heating           (heating),
    .keep_warm         (keep_warm),
    .done_pulse        (done_pulse),
    .fault             (fault),
    .fault_code        (fault_code)
  );

  // Output vector: {heater, heating, keep_warm, done_pulse, fault, fault_code[1:0]}
  localparam logic [6:0] ALL = 7'h7f;
  localparam logic [6:0] NH  = 7'h3f;  // heater depends on PWM phase here

  typedef struct {
    string      name;
    logic       st, cn, kw, wt;
    logic [7:0] tg, tp;
    logic [6:0] exp, care;
  } vec_t;

  typedef struct {
    string      name;
    logic [6:0] exp, care;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [6:0] outs();
    return {heater, heating, keep_warm, done_pulse, fault, fault_code};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic cn, input logic kw, input logic wt,
                       input logic [7:0] tg, input logic [7:0] tp);
    start_button       = st;
    cancel             = cn;
    keep_warm_en       = kw;
    water_level_sensor = wt;
    target_temp        = tg;
    temperature_sensor = tp;
  endtask

  task automatic add(input string nm, input logic st, input logic cn, input logic kw,
                     input logic wt, input logic [7:0] tg, input logic [7:0] tp,
                     input logic [6:0] e, input logic [6:0] c);
    vec_t v;
    v.name = nm; v.st = st; v.cn = cn; v.kw = kw; v.wt = wt;
    v.tg = tg; v.tp = tp; v.exp = e; v.care = c;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    sb_t s;
    drive(v.st, v.cn, v.kw, v.wt, v.tg, v.tp);
    s.name = v.name; s.exp = v.exp; s.care = v.care;
    sb_q.push_back(s);
    tick();
    s = sb_q.pop_front();
    check(s.name, 32'(outs() & s.care), 32'(s.exp & s.care));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //   name             st cn kw wt  tgt  temp  expected     care
    add("a_idle",         0, 0, 0, 1, 100,  20, 7'b0000000, ALL);
    add("a_start",        1, 0, 0, 1, 100,  20, 7'b0100000, ALL);
    add("a_heat",         1, 0, 0, 1, 100,  20, 7'b0100000, NH);
    add("a_done",         0, 0, 0, 1, 100, 100, 7'b0001000, NH);
    add("a_idle2",        0, 0, 0, 1, 100, 100, 7'b0000000, ALL);
    add("b_start",        1, 0, 1, 1, 100,  20, 7'b0100000, ALL);
    add("b_done_warm",    0, 0, 1, 1, 100, 100, 7'b0011000, NH);
    add("b_start_ign",    1, 0, 1, 1, 100, 100, 7'b0010000, ALL);
    add("b_warm_96",      0, 0, 1, 1, 100,  96, 7'b0010000, ALL);
    add("b_warm_on",      0, 0, 1, 1, 100,  94, 7'b0010000, ALL);
    add("b_heater_on",    0, 0, 1, 1, 100,  94, 7'b1010000, ALL);
    add("b_warm_off",     0, 0, 1, 1, 100, 100, 7'b1010000, ALL);
    add("b_heater_off",   0, 0, 1, 1, 100, 100, 7'b0010000, ALL);
    add("b_cancel",       0, 1, 1, 1, 100, 100, 7'b0000000, ALL);
    add("b_idle",         0, 0, 0, 1, 100,  20, 7'b0000000, ALL);
    add("c_start",        1, 0, 0, 1, 100,  20, 7'b0100000, ALL);
    add("c_ovt_wins",     0, 0, 0, 0, 100, 110, 7'b0000101, NH);
    add("c_fault",        0, 0, 0, 0, 100, 110, 7'b0000101, ALL);
    add("c_cancel_dry",   0, 1, 0, 0, 100, 104, 7'b0000101, ALL);
    add("c_cancel_105",   0, 1, 0, 1, 100, 105, 7'b0000101, ALL);
    add("c_recover",      0, 1, 0, 1, 100, 100, 7'b0000000, ALL);
    add("c_idle",         0, 0, 0, 1, 100,  20, 7'b0000000, ALL);
    add("d_start_dry",    1, 0, 0, 0, 200,  20, 7'b0000110, ALL);
    add("d_reeval_ovt",   0, 0, 0, 0, 200, 112, 7'b0000101, ALL);
    add("d_recover",      0, 1, 0, 1, 200,  20, 7'b0000000, ALL);
    add("d_idle",         0, 0, 0, 1, 200, 109, 7'b0000000, ALL);
    add("d_start_ign",    1, 0, 0, 1, 200, 109, 7'b0000000, ALL);
    add("d_idle2",        0, 0, 0, 1, 200, 108, 7'b0000000, ALL);
    add("d_start_108",    1, 0, 0, 1, 200, 108, 7'b0100000, ALL);
    add("d_tgt_latched",  0, 0, 0, 1,  20, 108, 7'b0100000, NH);
    add("d_cancel_done",  0, 1, 0, 1,  20, 109, 7'b0000000, NH);
    add("d_idle3",        0, 0, 0, 1, 100,  20, 7'b0000000, ALL);
    add("e_start",        1, 0, 0, 1, 100,  20, 7'b0100000, ALL);
    add("e_dry_cancel",   0, 1, 0, 0, 100,  20, 7'b0000110, NH);
    add("e_fault_hold",   0, 1, 0, 0, 100,  20, 7'b0000110, ALL);
    add("e_recover",      0, 1, 0, 1, 100,  20, 7'b0000000, ALL);
    add("e_idle",         0, 0, 0, 1, 100,  20, 7'b0000000, ALL);
    add("f_start",        1, 0, 1, 1,   3,   2, 7'b0100000, ALL);
    add("f_done",         0, 0, 1, 1,   3,   3, 7'b0011000, NH);
    add("f_hold_1",       0, 0, 1, 1,   3,   1, 7'b0010000, ALL);
    add("f_warm_on",      0, 0, 1, 1,   3,   0, 7'b0010000, ALL);
    add("f_heater",       0, 0, 1, 1,   3,   0, 7'b1010000, ALL);
    add("f_cancel",       0, 1, 1, 1,   3,   0, 7'b1000000, ALL);
    add("f_idle",         0, 0, 0, 1, 100,  20, 7'b0000000, ALL);

    rst = 1'b1;
    drive(0, 0, 0, 1, 100, 20);
    repeat (2) tick();
    check("reset_outputs", 32'(outs()), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i]);

    // Soft-start ramp: each duty level d lasts 64 cycles = 4 PWM periods.
    drive(1, 0, 0, 1, 100, 20);
    tick();
    check("ramp_enter_heating", 32'(outs()), 32'h20);
    start_button = 1'b0;
    for (int d = 1; d <= 17; d++) begin
      cnt = 0;
      repeat (64) begin
        tick();
        cnt += int'(heater);
      end
      check($sformatf("ramp_duty_%0d", d), 32'(cnt), 32'(4 * ((d > 16) ? 16 : d)));
    end

    // Reset in the middle of HEAT with the heater on, start held through it.
    check("pre_reset_heater", 32'(heater), 32'h1);
    start_button = 1'b1;
    rst = 1'b1;
    tick();
    check("reset_mid_heat", 32'(outs()), 32'h0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("held_start_no_edge", 32'(outs()), 32'h0);
    start_button = 1'b0;
    tick();
    drive(1, 0, 0, 1, 100, 50);
    tick();
    check("start_after_reset", 32'(outs()), 32'h20);
    start_button = 1'b0;

    // Timeout: 4096 cycles in HEAT, then FAULT(11), heater off a cycle later.
    repeat (4095) tick();
    check("tmo_still_heating", 32'({heating, fault}), 32'h2);
    tick();
    check("tmo_fault", 32'(outs()), 32'(7'b1000111));
    tick();
    check("tmo_heater_off", 32'(outs()), 32'(7'b0000111));
    cancel = 1'b1;
    tick();
    check("tmo_recover", 32'(outs()), 32'h0);
    cancel = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
